// File: rtl/bt_cmd_ctrl.sv
// Bluetooth UART command controller: parses HDR/CMD/ARG/CHK frames into player state and pulses.
// Optional feature macro AUTO_NEXT_EN: a rising edge of i_FINISH advances to the next song.
module bt_cmd_ctrl #(
    parameter int          SONG_NUM       = 4,
    parameter logic [7:0]  HDR            = 8'hA5,
    parameter logic [7:0]  VOL_INIT       = 8'h20,
    parameter logic [7:0]  VOL_STEP       = 8'h08,
    parameter logic [7:0]  VOL_MIN_ATT    = 8'hFE,
    parameter int unsigned TIMEOUT_CYCLES = 5_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    input  logic        i_FINISH,
    output logic [15:0] o_vol,
    output logic [2:0]  o_song_select,
    output logic        o_pause,
    output logic        o_next,
    output logic        o_pre,
    output logic        o_vol_plus,
    output logic        o_vol_dec,
    output logic        o_frame_err
);

    typedef enum logic [1:0] {S_IDLE, S_GET_CMD, S_GET_ARG, S_GET_CHK} state_t;

    localparam logic [7:0]  CMD_PAUSE   = 8'h01;
    localparam logic [7:0]  CMD_NEXT    = 8'h02;
    localparam logic [7:0]  CMD_PREV    = 8'h03;
    localparam logic [7:0]  CMD_VOL_UP  = 8'h04;
    localparam logic [7:0]  CMD_VOL_DN  = 8'h05;
    localparam logic [7:0]  CMD_SELECT  = 8'h06;
    localparam logic [7:0]  CMD_SET_VOL = 8'h07;
    localparam logic [2:0]  IDX_LAST    = 3'(SONG_NUM - 1);
    localparam logic [7:0]  SONG_NUM_B  = 8'(SONG_NUM);
    localparam logic [31:0] GAP_LAST    = 32'(TIMEOUT_CYCLES - 1);

    state_t      r_state, w_state_nxt;
    logic [7:0]  r_cmd, r_arg;
    logic [31:0] r_gap_cnt;
    logic [7:0]  r_att, w_att_nxt;
    logic [2:0]  r_idx, w_idx_nxt;
    logic        r_pause, w_pause_nxt;
    logic        r_next, r_pre, r_plus, r_dec, r_err;
    logic        w_next, w_pre, w_plus, w_dec, w_err;

    logic        w_exec, w_chk_ok, w_timeout, w_fin_rise;
    logic [2:0]  w_idx_inc, w_idx_dec;
    logic [7:0]  w_att_up, w_att_dn, w_arg_sat;
    logic [8:0]  w_att_sum;

`ifdef AUTO_NEXT_EN
    logic r_fin_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_fin_q <= 1'b0;
        else        r_fin_q <= i_FINISH;
    end

    assign w_fin_rise = i_FINISH & ~r_fin_q;
`else
    logic w_unused_finish;

    assign w_unused_finish = i_FINISH;
    assign w_fin_rise      = 1'b0;
`endif

    // A byte strobe in the same cycle as the last gap count suppresses the timeout.
    assign w_timeout = (r_state != S_IDLE) && !i_rx_valid && (r_gap_cnt == GAP_LAST);
    assign w_exec    = (r_state == S_GET_CHK) && i_rx_valid;
    assign w_chk_ok  = (i_rx_data == (r_cmd ^ r_arg));

    assign w_idx_inc = (r_idx == IDX_LAST) ? 3'd0 : r_idx + 3'd1;
    assign w_idx_dec = (r_idx == 3'd0) ? IDX_LAST : r_idx - 3'd1;
    assign w_att_up  = (r_att < VOL_STEP) ? 8'h00 : r_att - VOL_STEP;
    assign w_att_sum = {1'b0, r_att} + {1'b0, VOL_STEP};
    assign w_att_dn  = (w_att_sum > {1'b0, VOL_MIN_ATT}) ? VOL_MIN_ATT : w_att_sum[7:0];
    assign w_arg_sat = (r_arg > VOL_MIN_ATT) ? VOL_MIN_ATT : r_arg;

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        if (w_timeout) begin
            w_state_nxt = S_IDLE;
        end else if (i_rx_valid) begin
            case (r_state)
                S_IDLE:    if (i_rx_data == HDR) w_state_nxt = S_GET_CMD;
                S_GET_CMD: w_state_nxt = S_GET_ARG;
                S_GET_ARG: w_state_nxt = S_GET_CHK;
                default:   w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_idx_nxt   = r_idx;
        w_att_nxt   = r_att;
        w_pause_nxt = r_pause;
        w_next      = 1'b0;
        w_pre       = 1'b0;
        w_plus      = 1'b0;
        w_dec       = 1'b0;
        w_err       = 1'b0;
        if (w_exec) begin
            if (!w_chk_ok) begin
                w_err = 1'b1;
            end else begin
                case (r_cmd)
                    CMD_PAUSE:   w_pause_nxt = ~r_pause;
                    CMD_NEXT:    begin w_idx_nxt = w_idx_inc; w_next = 1'b1; end
                    CMD_PREV:    begin w_idx_nxt = w_idx_dec; w_pre  = 1'b1; end
                    CMD_VOL_UP:  begin w_att_nxt = w_att_up; w_plus = (w_att_up != r_att); end
                    CMD_VOL_DN:  begin w_att_nxt = w_att_dn; w_dec  = (w_att_dn != r_att); end
                    CMD_SELECT: begin
                        if (r_arg < SONG_NUM_B) w_idx_nxt = r_arg[2:0];
                        else                    w_err     = 1'b1;
                    end
                    CMD_SET_VOL: w_att_nxt = w_arg_sat;
                    default:     w_err = 1'b1;
                endcase
            end
        end else if (w_fin_rise) begin
            // Any executing command consumes the end-of-track edge.
            w_idx_nxt = w_idx_inc;
            w_next    = 1'b1;
        end
        if (w_timeout) w_err = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cmd     <= 8'h00;
            r_arg     <= 8'h00;
            r_gap_cnt <= 32'd0;
            r_att     <= VOL_INIT;
            r_idx     <= 3'd0;
            r_pause   <= 1'b0;
            r_next    <= 1'b0;
            r_pre     <= 1'b0;
            r_plus    <= 1'b0;
            r_dec     <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (i_rx_valid && r_state == S_GET_CMD) r_cmd <= i_rx_data;
            if (i_rx_valid && r_state == S_GET_ARG) r_arg <= i_rx_data;
            if (i_rx_valid)                 r_gap_cnt <= 32'd0;
            else if (r_gap_cnt != '1)       r_gap_cnt <= r_gap_cnt + 32'd1;
            r_att   <= w_att_nxt;
            r_idx   <= w_idx_nxt;
            r_pause <= w_pause_nxt;
            r_next  <= w_next;
            r_pre   <= w_pre;
            r_plus  <= w_plus;
            r_dec   <= w_dec;
            r_err   <= w_err;
        end
    end

    assign o_vol         = {r_att, r_att};
    assign o_song_select = r_idx;
    assign o_pause       = r_pause;
    assign o_next        = r_next;
    assign o_pre         = r_pre;
    assign o_vol_plus    = r_plus;
    assign o_vol_dec     = r_dec;
    assign o_frame_err   = r_err;

endmodule

// File: tb/tb_bt_cmd_ctrl.sv
// Self-checking bench for bt_cmd_ctrl: directed frames, timeout, reset and randomized frames
// against a behavioural player model.
module tb_bt_cmd_ctrl;

    localparam int         SONG_NUM = 4;
    localparam int         TO       = 64;
    localparam logic [7:0] HDR      = 8'hA5;
    localparam int         STEP     = 8;
    localparam int         MIN_ATT  = 254;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  i_rx_data;
    logic        i_rx_valid;
    logic        i_FINISH;
    logic [15:0] o_vol;
    logic [2:0]  o_song_select;
    logic        o_pause, o_next, o_pre, o_vol_plus, o_vol_dec, o_frame_err;

    bt_cmd_ctrl #(.SONG_NUM(SONG_NUM), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
        .i_FINISH(i_FINISH), .o_vol(o_vol), .o_song_select(o_song_select), .o_pause(o_pause),
        .o_next(o_next), .o_pre(o_pre), .o_vol_plus(o_vol_plus), .o_vol_dec(o_vol_dec),
        .o_frame_err(o_frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Player model: song index, pause flag, attenuation.
    int m_idx, m_pause, m_att;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse vector order: {next, pre, vol_plus, vol_dec, frame_err}
    task automatic check_pulses(input string tag, input logic [4:0] exp);
        check({tag, "_pulses"}, {27'd0, o_next, o_pre, o_vol_plus, o_vol_dec, o_frame_err},
              {27'd0, exp});
    endtask

    task automatic check_state(input string tag);
        check({tag, "_idx"},   {29'd0, o_song_select}, m_idx);
        check({tag, "_pause"}, {31'd0, o_pause},       m_pause);
        check({tag, "_vol"},   {16'd0, o_vol},         (m_att << 8) | m_att);
    endtask

    task automatic model_reset();
        m_idx = 0; m_pause = 0; m_att = 8'h20;
    endtask

    task automatic model_frame(input int cmd, input int arg, input int chk,
                               output logic [4:0] p);
        int n;
        p = 5'b0;
        if (chk != (cmd ^ arg)) p[0] = 1'b1;
        else begin
            case (cmd)
                1: m_pause = 1 - m_pause;
                2: begin m_idx = (m_idx + 1) % SONG_NUM; p[4] = 1'b1; end
                3: begin m_idx = (m_idx + SONG_NUM - 1) % SONG_NUM; p[3] = 1'b1; end
                4: begin
                    n = m_att - STEP;
                    if (n < 0) n = 0;
                    p[2] = (n != m_att);
                    m_att = n;
                end
                5: begin
                    n = m_att + STEP;
                    if (n > MIN_ATT) n = MIN_ATT;
                    p[1] = (n != m_att);
                    m_att = n;
                end
                6: if (arg < SONG_NUM) m_idx = arg; else p[0] = 1'b1;
                7: m_att = (arg > MIN_ATT) ? MIN_ATT : arg;
                default: p[0] = 1'b1;
            endcase
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; the byte is sampled on the following posedge.
    task automatic send_byte(input logic [7:0] b);
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        @(negedge clk);
        i_rx_valid = 1'b0;
    endtask

    task automatic run_frame(input string tag, input int cmd, input int arg, input int chk,
                             input int max_gap);
        logic [4:0] p;
        send_byte(HDR);             idle($urandom_range(0, max_gap));
        send_byte(8'(cmd));         idle($urandom_range(0, max_gap));
        send_byte(8'(arg));         idle($urandom_range(0, max_gap));
        send_byte(8'(chk));
        model_frame(cmd, arg, chk, p);
        check_pulses(tag, p);
        check_state(tag);
        idle(1);
        check_pulses({tag, "_after"}, 5'b0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int first_err, err_cnt, cmd, arg, chk;
        logic [7:0] junk;

        rst_n = 1'b0; i_rx_data = 8'h00; i_rx_valid = 1'b0; i_FINISH = 1'b0;
        model_reset();
        idle(3);
        check_state("reset");
        check_pulses("reset", 5'b0);
        rst_n = 1'b1;
        idle(2);
        check_state("post_reset");

        // Song navigation with wrap
        run_frame("next_0_1", 2, 0, 2, 0);
        run_frame("prev_1_0", 3, 0, 3, 1);
        run_frame("prev_wrap", 3, 0, 3, 2);
        run_frame("next_wrap", 2, 0, 2, 2);

        // Volume bounds
        run_frame("setvol_04", 7, 8'h04, 8'h03, 1);
        run_frame("volup_to_0", 4, 0, 4, 1);
        run_frame("volup_at_0", 4, 0, 4, 1);
        run_frame("setvol_ff", 7, 8'hFF, 8'hF8, 1);
        run_frame("voldn_at_min", 5, 0, 5, 1);
        run_frame("voldn_from_f8", 7, 8'hF8, 8'hFF, 0);
        run_frame("voldn_sat", 5, 0, 5, 0);

        // Errors
        run_frame("bad_chk", 1, 0, 0, 1);
        run_frame("sel_range", 6, 5, 3, 1);
        run_frame("sel_ok", 6, 2, 4, 1);
        run_frame("hdr_as_arg", 6, 8'hA5, 8'hA3, 1);
        run_frame("unknown_cmd", 8'h09, 8'h11, 8'h18, 1);

        // Non-header bytes in IDLE are dropped silently
        send_byte(8'h11);
        check_pulses("junk_11", 5'b0);
        send_byte(8'h02);
        check_pulses("junk_02", 5'b0);
        check_state("junk");

        // Inter-byte timeout
        send_byte(HDR);
        send_byte(8'h02);
        first_err = -1;
        err_cnt   = 0;
        for (int k = 1; k <= TO + 4; k++) begin
            @(negedge clk);
            if (o_frame_err) begin
                err_cnt++;
                if (first_err < 0) first_err = k;
            end
        end
        check("timeout_window", {31'd0, (first_err >= TO - 1) && (first_err <= TO + 1)}, 1);
        check("timeout_single", err_cnt, 1);
        check_state("timeout");
        run_frame("pause_after_to", 1, 0, 1, 0);

        // Byte arriving on the last gap cycle wins over the timeout
        send_byte(HDR);
        send_byte(8'h02);
        idle(TO - 1);
        send_byte(8'h00);
        check_pulses("to_race_byte", 5'b0);
        begin
            logic [4:0] p;
            send_byte(8'h02);
            model_frame(2, 0, 2, p);
            check_pulses("to_race_exec", p);
            check_state("to_race_exec");
        end
        check("pause_kept", {31'd0, o_pause}, 1);

        // Randomized frames
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                junk = 8'($urandom);
                if (junk == HDR) junk = 8'h00;
                send_byte(junk);
            end
            cmd = $urandom_range(0, 8);
            arg = (cmd == 6) ? $urandom_range(0, 7) : $urandom_range(0, 255);
            chk = cmd ^ arg;
            if ($urandom_range(0, 7) == 0) chk = chk ^ $urandom_range(1, 255);
            run_frame("rand", cmd, arg, chk, 3);
        end

        // Reset in the middle of a frame discards it
        send_byte(HDR);
        send_byte(8'h02);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_state("mid_reset");
        idle(2);
        rst_n = 1'b1;
        idle(1);
        send_byte(8'h00);
        send_byte(8'h02);
        check_pulses("mid_reset_tail", 5'b0);
        check_state("mid_reset_tail");

        // End-of-track input
`ifdef AUTO_NEXT_EN
        i_FINISH = 1'b1;
        @(negedge clk);
        m_idx = (m_idx + 1) % SONG_NUM;
        check_pulses("finish_rise", 5'b10000);
        check_state("finish_rise");
        @(negedge clk);
        check_pulses("finish_after", 5'b0);
        i_FINISH = 1'b0;
        idle(2);
        send_byte(HDR);
        send_byte(8'h02);
        send_byte(8'h00);
        i_FINISH = 1'b1;
        begin
            logic [4:0] p;
            send_byte(8'h02);
            model_frame(2, 0, 2, p);
            check_pulses("finish_coinc", p);
            check_state("finish_coinc");
        end
        idle(1);
        check_pulses("finish_coinc_after", 5'b0);
        check_state("finish_coinc_after");
        i_FINISH = 1'b0;
        idle(1);
`else
        i_FINISH = 1'b1;
        @(negedge clk);
        check_pulses("finish_ignored", 5'b0);
        idle(2);
        check_state("finish_ignored");
        i_FINISH = 1'b0;
        idle(1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
